// File: rtl/shared_cnt_pkg.sv
// Shared definitions for the shared counter controller: subcounter command
// encodings, request op codes and the controller state type.
package shared_cnt_pkg;

  localparam logic [1:0] CMD_CLR  = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b01;
  localparam logic [1:0] CMD_HOLD = 2'b10;

  localparam logic OP_INC = 1'b0;
  localparam logic OP_CLR = 1'b1;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/shared_counter_ctrl_group_decode.sv
// group_decode: combinational group extent, id legality and carry lookahead
// for a request aimed at the group whose base subcounter is req_id.
module group_decode
  import shared_cnt_pkg::*;
#(
  parameter int granularity = 4,
  parameter int NUM_SUB     = 4
) (
  input  logic [NUM_SUB-2:0]                   bound_mask,
  input  logic [$clog2(NUM_SUB)-1:0]           req_id,
  input  logic [NUM_SUB-1:0][granularity-1:0]  sub_data,
  output logic [NUM_SUB-1:0]                   member,
  output logic                                 legal,
  output logic [NUM_SUB-1:0]                   inc_en,
  output logic                                 all_ones
);

  // starts[i]: subcounter i is the base of some group (sub 0 always is)
  logic [NUM_SUB-1:0] starts;
  logic [NUM_SUB-1:0] sub_full;
  logic               in_grp;
  logic               carry;

  assign starts = {bound_mask, 1'b1};

  for (genvar g = 0; g < NUM_SUB; g++) begin : g_full
    assign sub_full[g] = &sub_data[g];
  end

  // Walk upward from the base: membership ends at the next group start, and
  // the carry into each member is the AND of all-ones of the members below it.
  always_comb begin
    member = '0;
    inc_en = '0;
    legal  = 1'b0;
    in_grp = 1'b0;
    carry  = 1'b1;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (i == int'(req_id)) begin
        in_grp = 1'b1;
        legal  = starts[i];
      end else if (starts[i]) begin
        in_grp = 1'b0;
      end
      member[i] = in_grp;
      inc_en[i] = in_grp & carry;
      if (in_grp) carry = carry & sub_full[i];
    end
    all_ones = carry;
  end

endmodule

// File: rtl/shared_counter_ctrl.sv
// Command controller for an array of subcounters partitioned into groups.
// Optional SHARED_CNT_OVF_STICKY_EN adds a sticky per-group ovf_status port.
module shared_counter_ctrl
  import shared_cnt_pkg::*;
#(
  parameter int granularity = 4,
  parameter int NUM_SUB     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_op,
  input  logic [$clog2(NUM_SUB)-1:0]       req_id,
  input  logic [NUM_SUB-2:0]               bound_mask,
  input  logic [granularity*NUM_SUB-1:0]   sub_data_in,
  output logic [2*NUM_SUB-1:0]             sub_command_out,
  output logic                             ovf,
  output logic                             req_err
`ifdef SHARED_CNT_OVF_STICKY_EN
  ,
  output logic [NUM_SUB-1:0]               ovf_status
`endif
);

  state_t                               state;
  logic [NUM_SUB-1:0][1:0]              cmd_q;
  logic [NUM_SUB-1:0][1:0]              next_cmd;
  logic [NUM_SUB-1:0][granularity-1:0]  sub_data;
  logic [NUM_SUB-1:0]                   member;
  logic [NUM_SUB-1:0]                   inc_en;
  logic                                 legal;
  logic                                 all_ones;
  logic                                 accept;

  assign sub_data        = sub_data_in;
  assign sub_command_out = cmd_q;
  assign accept          = (state == IDLE) && req_valid && req_ready;

  group_decode #(
    .granularity (granularity),
    .NUM_SUB     (NUM_SUB)
  ) u_decode (
    .bound_mask (bound_mask),
    .req_id     (req_id),
    .sub_data   (sub_data),
    .member     (member),
    .legal      (legal),
    .inc_en     (inc_en),
    .all_ones   (all_ones)
  );

  // An illegal id is consumed but leaves every subcounter on hold
  always_comb begin
    next_cmd = '0;
    for (int i = 0; i < NUM_SUB; i++) begin
      next_cmd[i] = CMD_HOLD;
      if (legal && member[i])
        next_cmd[i] = (req_op == OP_CLR) ? CMD_CLR :
                      (inc_en[i] ? CMD_INC : CMD_HOLD);
    end
  end

  // Reset drives CLR so the unreset subcounters are zeroed through INIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      req_ready <= 1'b0;
      cmd_q     <= {NUM_SUB{CMD_CLR}};
      ovf       <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          cmd_q     <= {NUM_SUB{CMD_HOLD}};
        end
        IDLE: begin
          if (accept) begin
            state     <= ISSUE;
            req_ready <= 1'b0;
            cmd_q     <= next_cmd;
            ovf       <= legal && (req_op == OP_INC) && all_ones;
            req_err   <= !legal;
          end
        end
        ISSUE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          cmd_q     <= {NUM_SUB{CMD_HOLD}};
          ovf       <= 1'b0;
          req_err   <= 1'b0;
        end
        default: begin
          state     <= INIT;
          req_ready <= 1'b0;
          cmd_q     <= {NUM_SUB{CMD_CLR}};
          ovf       <= 1'b0;
          req_err   <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHARED_CNT_OVF_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_status <= '0;
    end else if (accept && legal) begin
      if (req_op == OP_CLR)
        ovf_status[req_id] <= 1'b0;
      else if (all_ones)
        ovf_status[req_id] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shared_counter_ctrl.sv
// Bench for shared_counter_ctrl: behavioural subcounter array, table-driven
// request rows, scoreboard of per-request commands and hand-written corners.
module tb_shared_counter_ctrl;

  localparam int G = 4;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_op = 1'b0;
  logic [1:0]   req_id = '0;
  logic [2:0]   bound_mask = '0;
  logic [15:0]  sub_data_in;
  logic [7:0]   sub_command_out;
  logic         ovf;
  logic         req_err;
`ifdef SHARED_CNT_OVF_STICKY_EN
  logic [3:0]   ovf_status;
`endif

  // Subcounters have no reset; start them at junk so clearing is visible
  logic [3:0] sub_q [N] = '{4'h3, 4'h9, 4'hC, 4'h6};

  typedef struct {
    logic [7:0] cmd;
    logic       ovf;
    logic       err;
  } exp_t;

  typedef struct {
    logic        op;
    logic [1:0]  id;
    logic [2:0]  mask;
    int          reps;
    logic [15:0] exp_val;
    int          exp_ovf;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   ovf_seen = 0;

  shared_counter_ctrl #(.granularity(G), .NUM_SUB(N)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_id          (req_id),
    .bound_mask      (bound_mask),
    .sub_data_in     (sub_data_in),
    .sub_command_out (sub_command_out),
    .ovf             (ovf),
    .req_err         (req_err)
`ifdef SHARED_CNT_OVF_STICKY_EN
    ,
    .ovf_status      (ovf_status)
`endif
  );

  always #5 clk = ~clk;

  assign sub_data_in = {sub_q[3], sub_q[2], sub_q[1], sub_q[0]};

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      case (sub_command_out[2*i +: 2])
        2'b00:   sub_q[i] <= 4'h0;
        2'b01:   sub_q[i] <= sub_q[i] + 4'h1;
        default: sub_q[i] <= sub_q[i];
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cur_val();
    return {sub_q[3], sub_q[2], sub_q[1], sub_q[0]};
  endfunction

  // Expected issue outputs: treat the group as one wide counter; a
  // subcounter increments exactly when its nibble of value+1 differs.
  function automatic exp_t model(input logic op, input logic [1:0] id, input logic [2:0] mask);
    exp_t        r;
    logic [3:0]  st;
    logic [31:0] val, nv, msk;
    int          b, e, w;
    st  = {mask, 1'b1};
    b   = int'(id);
    e   = b + 1;
    while (e < N && !st[e]) e++;
    w   = 4 * (e - b);
    msk = (32'h1 << w) - 32'h1;
    val = '0;
    for (int i = b; i < e; i++) val[4*(i-b) +: 4] = sub_q[i];
    nv  = (val + 32'h1) & msk;
    r.cmd = 8'hAA;
    r.err = !st[b];
    r.ovf = st[b] && !op && (nv == 32'h0);
    if (st[b]) begin
      for (int i = b; i < e; i++)
        r.cmd[2*i +: 2] = op ? 2'b00 :
                          ((nv[4*(i-b) +: 4] != val[4*(i-b) +: 4]) ? 2'b01 : 2'b10);
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge of the ISSUE cycle
  task automatic send(input logic op, input logic [1:0] id, input logic [2:0] mask);
    exp_t e;
    bit   ok = 0;
    req_op = op; req_id = id; bound_mask = mask; req_valid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      if (req_ready) begin
        e = model(op, id, mask);
        @(posedge clk); #1;
        sb.push_back(e);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=no_accept expected=accept");
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("issue_cmd", {24'h0, sub_command_out}, {24'h0, e.cmd});
      chk("issue_ovf", {31'h0, ovf}, {31'h0, e.ovf});
      chk("issue_err", {31'h0, req_err}, {31'h0, e.err});
      if (ovf) ovf_seen++;
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_cmd"},   {24'h0, sub_command_out}, 32'h00);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h0);
    chk({tag, "_ovf"},   {31'h0, ovf}, 32'h0);
    chk({tag, "_err"},   {31'h0, req_err}, 32'h0);
  endtask

  task automatic post_reset_checks(input string tag);
    chk({tag, "_cmd"},   {24'h0, sub_command_out}, 32'hAA);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_subs"},  {16'h0, cur_val()}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[10];
    logic [15:0] base;
    int          acc, ov0;
    bit          pat_ok, r;
    exp_t        e;

    tbl[0] = '{1'b0, 2'd0, 3'b000, 17,  16'h0011, 0};
    tbl[1] = '{1'b1, 2'd0, 3'b000, 1,   16'h0000, 0};
    tbl[2] = '{1'b0, 2'd2, 3'b010, 256, 16'h0000, 1};
    tbl[3] = '{1'b0, 2'd2, 3'b010, 90,  16'h5A00, 0};
    tbl[4] = '{1'b0, 2'd0, 3'b010, 3,   16'h5A03, 0};
    tbl[5] = '{1'b1, 2'd2, 3'b010, 1,   16'h0003, 0};
    tbl[6] = '{1'b0, 2'd1, 3'b000, 1,   16'h0003, 0};
    tbl[7] = '{1'b0, 2'd3, 3'b100, 20,  16'h4003, 1};
    tbl[8] = '{1'b0, 2'd1, 3'b001, 1,   16'h4013, 0};
    tbl[9] = '{1'b1, 2'd1, 3'b001, 1,   16'h0003, 0};

    // Power-on reset: commands clear, then hold once INIT passes
    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst_n = 1'b1;
    @(negedge clk);
    post_reset_checks("init");

    for (int v = 0; v < 10; v++) begin
      ov0 = ovf_seen;
      for (int k = 0; k < tbl[v].reps; k++) send(tbl[v].op, tbl[v].id, tbl[v].mask);
      @(negedge clk);
      chk($sformatf("row%0d_value", v), {16'h0, cur_val()}, {16'h0, tbl[v].exp_val});
      chk($sformatf("row%0d_ovf_count", v), ovf_seen - ov0, tbl[v].exp_ovf);
    end

    // Back-to-back: valid held for 10 cycles
    base = cur_val();
    acc = 0; pat_ok = 1;
    req_op = 1'b0; req_id = 2'd0; bound_mask = 3'b000; req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      r = req_ready;
      if (r != (k % 2 == 0)) pat_ok = 0;
      if (r) e = model(1'b0, 2'd0, 3'b000);
      @(posedge clk); #1;
      if (r) begin sb.push_back(e); acc++; end
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_accepts", acc, 5);
    chk("b2b_ready_pattern", {31'h0, pat_ok}, 32'h1);
    chk("b2b_value", {16'h0, cur_val()}, {16'h0, base + 16'd5});

    // Reset during ISSUE abandons the command and clears everything
    send(1'b0, 2'd0, 3'b000);
    #1 rst_n = 1'b0;
    #1 reset_checks("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    post_reset_checks("midrst_post");

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
